pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program-counter generator for the fetch stage; successor to the fixed 32-bit, single-source PC register.
- Generalised in address width, reset vector and instruction step.
- Adds prioritised redirect sources (flush over branch), a fetch-ready handshake, capture of redirects that arrive while the PC is held, and a target-alignment check.
- Feeds the instruction-fetch address bus and chip-enable to instruction memory.

Parameters:
ADDR_W, 32, PC and target width in bits
RESET_VECTOR, 32'h00000000, PC value presented on the first fetch after reset
STEP, 4, sequential increment in bytes (power of two, at least 1)
ALIGN_BITS, 2, low target bits that must be zero (log2 of STEP)
STALL_W, 6, width of the pipeline stall bus; only bit 0 is used here

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
stall  in  STALL_W  pipeline stall bus; stall[0]=1 holds the PC
fetch_ready  in  1  instruction memory accepts the current pc this cycle
branch_flag_i  in  1  branch/jump taken, valid for one cycle
branch_target_address_i  in  ADDR_W  branch target
flush_i  in  1  exception/flush redirect, one-cycle pulse; overrides branch
flush_target_i  in  ADDR_W  flush/handler target
pc  out  ADDR_W  current fetch address
ce  out  1  fetch enable (1 = pc valid)
misalign_o  out  1  one-cycle pulse: an applied target had nonzero low ALIGN_BITS

Behaviour:
- Reset and enable:
  - Synchronous active-high reset.
  - While rst=1: ce=0, pc=RESET_VECTOR, misalign_o=0, pending redirect cleared.
  - ce is registered. It goes to 1 on the first rising edge with rst=0, so ce lags reset release by one cycle.
  - While ce=0, pc holds RESET_VECTOR and all inputs are ignored, including flush and branch.
- Advance condition: adv = ce & ~stall[0] & fetch_ready.
- Redirect selection each cycle (ce=1):
  - flush_i=1 → req = flush_target_i.
  - else branch_flag_i=1 → req = branch_target_address_i.
  - else req = none.
- Pending redirect register: pend_v, pend_addr.
- Next pc when adv=1, in priority order:
  1. New req this cycle → pc <= req; pend_v <= 0.
  2. else pend_v=1 → pc <= pend_addr; pend_v <= 0.
  3. else → pc <= pc + STEP, wrapping modulo 2^ADDR_W (all-ones region + STEP wraps to low addresses; no flag).
- When adv=0 (stalled or memory not ready):
  - pc holds.
  - A new req is captured: pend_v <= 1, pend_addr <= req. A later req overwrites an older pending one; a flush always wins over a same-cycle branch.
- Alignment:
  - Any target written to pc or pend_addr has its low ALIGN_BITS forced to 0.
  - misalign_o pulses for one cycle, registered, in the cycle after a req whose low ALIGN_BITS were nonzero is accepted (applied or captured).
  - At most one pulse per accepted req.
- Reset mid-operation: rst=1 discards pend_v and any in-flight redirect the same edge; pc returns to RESET_VECTOR.
- No combinational path from any input to pc or ce; both are pure registers. Latency from redirect input to pc is one cycle when adv=1.

Test Plan:
- Reset release, defaults (RESET_VECTOR=0, STEP=4), stall=0, fetch_ready=1:
  - rst high 3 cycles then low → ce=0 & pc=0 during reset.
  - ce=1 one cycle after release.
  - pc sequence 0,4,8,0xC on successive cycles.
- Branch at pc=0x10 with target 0x100, no stall → next pc=0x100, then 0x104; misalign_o stays 0.
- Stall capture, pc=0x20:
  - stall[0]=1 for 3 cycles; branch pulse (target 0x200) in the first stall cycle → pc holds 0x20.
  - On release, next pc=0x200 (not 0x24), then 0x204.
- Simultaneous and overwrite:
  - flush_i and branch_flag_i in the same cycle (flush 0x80000180, branch 0x300) → pc=0x80000180.
  - With fetch_ready=0: branch to 0x300 followed next cycle by flush to 0x180 → after ready returns, pc=0x180.
- Misaligned target 0x203 → pc=0x200 and a single misalign_o pulse the following cycle.
- Wrap: pc=0xFFFFFFFC, adv=1, no redirect → pc=0x00000000.
- Mid-run reset with a pending redirect:
  - rst=1 → pc=RESET_VECTOR, ce=0, pending discarded.
  - After release, fetch restarts at RESET_VECTOR.

Source files
------------

// File: rtl/pc_unit.sv
// ============================================================================
// Module   : pc_unit
// Brief    : Fetch-stage program counter with prioritised redirects
//            (flush over branch), fetch-ready handshake, capture of redirects
//            that arrive while held, and target-alignment checking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_unit #(
  parameter int unsigned            ADDR_W       = 32,
  parameter logic [ADDR_W-1:0]      RESET_VECTOR = 32'h00000000,
  parameter int unsigned            STEP         = 4,
  parameter int unsigned            ALIGN_BITS   = 2,
  parameter int unsigned            STALL_W      = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic                fetch_ready,
  input  logic                branch_flag_i,
  input  logic [ADDR_W-1:0]   branch_target_address_i,
  input  logic                flush_i,
  input  logic [ADDR_W-1:0]   flush_target_i,
  output logic [ADDR_W-1:0]   pc,
  output logic                ce,
  output logic                misalign_o
);

  localparam logic [ADDR_W-1:0] c_low_mask = ADDR_W'((64'd1 << ALIGN_BITS) - 64'd1);
  localparam logic [ADDR_W-1:0] c_step     = ADDR_W'(STEP);

  logic [ADDR_W-1:0] r_pc;
  logic              r_ce;
  logic              r_misalign;
  logic              r_pend_v;
  logic [ADDR_W-1:0] r_pend_addr;

  logic              w_adv;
  logic              w_req_v;
  logic [ADDR_W-1:0] w_req;
  logic [ADDR_W-1:0] w_req_aligned;
  logic              w_req_misaligned;

  // Upper stall bits belong to other pipeline stages.
  generate
    if (STALL_W > 1) begin : g_stall_unused
      logic w_unused_stall;
      assign w_unused_stall = &{1'b0, stall[STALL_W-1:1]};
    end
  endgenerate

  always_comb begin
    w_adv            = r_ce & ~stall[0] & fetch_ready;
    w_req_v          = r_ce & (flush_i | branch_flag_i);
    w_req            = flush_i ? flush_target_i : branch_target_address_i;
    w_req_aligned    = w_req & ~c_low_mask;
    w_req_misaligned = |(w_req & c_low_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ce        <= 1'b0;
      r_pc        <= RESET_VECTOR;
      r_misalign  <= 1'b0;
      r_pend_v    <= 1'b0;
      r_pend_addr <= '0;
    end else begin
      r_ce       <= 1'b1;
      r_misalign <= w_req_v & w_req_misaligned;
      if (w_adv) begin
        if (w_req_v) begin
          r_pc <= w_req_aligned;
        end else if (r_pend_v) begin
          r_pc <= r_pend_addr;
        end else begin
          r_pc <= r_pc + c_step;
        end
        r_pend_v <= 1'b0;
      end else if (w_req_v) begin
        // Newest redirect replaces any older one still waiting.
        r_pend_v    <= 1'b1;
        r_pend_addr <= w_req_aligned;
      end
    end
  end

  assign pc         = r_pc;
  assign ce         = r_ce;
  assign misalign_o = r_misalign;

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
// ============================================================================
// Module   : tb_pc_unit
// Brief    : Self-checking scoreboard bench for pc_unit (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        fetch_ready;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic        flush_i;
  logic [31:0] flush_target_i;
  logic [31:0] pc;
  logic        ce;
  logic        misalign_o;

  pc_unit dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .fetch_ready             (fetch_ready),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .flush_i                 (flush_i),
    .flush_target_i          (flush_target_i),
    .pc                      (pc),
    .ce                      (ce),
    .misalign_o              (misalign_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        ce;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  // Reference state derived from the behavioural description
  logic [31:0] m_pc;
  logic        m_ce;
  logic        m_pv;
  logic [31:0] m_pa;
  logic        m_mis;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic [5:0] s, input logic rdy,
                      input logic br, input logic [31:0] bt,
                      input logic fl, input logic [31:0] ft);
    logic        adv, req_v;
    logic [31:0] req, ra;
    exp_t        e, o;
    rst = r; stall = s; fetch_ready = rdy;
    branch_flag_i = br; branch_target_address_i = bt;
    flush_i = fl; flush_target_i = ft;
    if (r) begin
      m_ce = 1'b0; m_pc = 32'h0; m_pv = 1'b0; m_mis = 1'b0;
    end else begin
      adv   = m_ce & ~s[0] & rdy;
      req_v = m_ce & (fl | br);
      req   = fl ? ft : bt;
      ra    = {req[31:2], 2'b00};
      m_mis = req_v & (req[1:0] != 2'b00);
      if (adv) begin
        if (req_v)     m_pc = ra;
        else if (m_pv) m_pc = m_pa;
        else           m_pc = m_pc + 32'd4;
        m_pv = 1'b0;
      end else if (req_v) begin
        m_pv = 1'b1;
        m_pa = ra;
      end
      m_ce = 1'b1;
    end
    e.pc = m_pc; e.ce = m_ce; e.mis = m_mis;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      o = exp_q.pop_front();
      check("sb_pc", pc, o.pc);
      check("sb_ce", {31'd0, ce}, {31'd0, o.ce});
      check("sb_misalign", {31'd0, misalign_o}, {31'd0, o.mis});
    end
  endtask

  task automatic idle();
    step(1'b0, 6'd0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic branch(input logic [31:0] t);
    step(1'b0, 6'd0, 1'b1, 1'b1, t, 1'b0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; stall = '0; fetch_ready = 1'b1;
    branch_flag_i = 1'b0; branch_target_address_i = '0;
    flush_i = 1'b0; flush_target_i = '0;
    m_pa = '0;
    #1;

    // Reset held three cycles, with a redirect that must be ignored
    for (int i = 0; i < 3; i++)
      step(1'b1, 6'd0, 1'b1, 1'b1, 32'h500, 1'b0, 32'h0);
    check("rst_ce", {31'd0, ce}, 32'd0);
    check("rst_pc", pc, 32'h0);

    idle();
    check("first_ce", {31'd0, ce}, 32'd1);
    check("first_pc", pc, 32'h0);
    idle(); check("seq_4", pc, 32'h4);
    idle(); check("seq_8", pc, 32'h8);
    idle(); check("seq_c", pc, 32'hC);
    idle(); check("seq_10", pc, 32'h10);

    branch(32'h100);
    check("br_pc", pc, 32'h100);
    check("br_mis", {31'd0, misalign_o}, 32'd0);
    idle(); check("br_next", pc, 32'h104);

    // Stall capture
    branch(32'h20);
    step(1'b0, 6'd1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
    step(1'b0, 6'd1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 6'd1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check("stall_hold", pc, 32'h20);
    idle(); check("stall_redirect", pc, 32'h200);
    idle(); check("stall_next", pc, 32'h204);

    // Flush beats a same-cycle branch
    step(1'b0, 6'd0, 1'b1, 1'b1, 32'h300, 1'b1, 32'h80000180);
    check("flush_prio", pc, 32'h80000180);

    // Later pending redirect overwrites earlier one
    step(1'b0, 6'd0, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0);
    step(1'b0, 6'd0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h180);
    idle(); check("overwrite", pc, 32'h180);

    // Misaligned target
    branch(32'h203);
    check("mis_pc", pc, 32'h200);
    check("mis_pulse", {31'd0, misalign_o}, 32'd1);
    idle(); check("mis_once", {31'd0, misalign_o}, 32'd0);

    // Misaligned target captured while not ready still pulses once
    step(1'b0, 6'd0, 1'b0, 1'b1, 32'h401, 1'b0, 32'h0);
    check("mis_cap_pulse", {31'd0, misalign_o}, 32'd1);
    idle(); check("mis_cap_pc", pc, 32'h400);

    // Wrap-around
    branch(32'hFFFFFFF8);
    idle(); check("wrap_fc", pc, 32'hFFFFFFFC);
    idle(); check("wrap_0", pc, 32'h0);

    // Mid-run reset with a pending redirect
    idle();
    step(1'b0, 6'd1, 1'b1, 1'b1, 32'h800, 1'b0, 32'h0);
    step(1'b1, 6'd0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h900);
    check("mid_rst_ce", {31'd0, ce}, 32'd0);
    check("mid_rst_pc", pc, 32'h0);
    idle(); check("restart_pc", pc, 32'h0);
    idle(); check("pend_dropped", pc, 32'h4);

    // Random traffic, including unused stall bits
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 49) == 0), 6'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 4) == 0), $urandom,
           ($urandom_range(0, 9) == 0), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
